// File: rtl/demux4_buf.sv
// -----------------------------------------------------------------------------
// demux4_buf
//
// One-to-four demultiplexer with a single-word output buffer per channel.
// An incoming word is steered to one of four channels, either by the explicit
// sel input or by an internal round-robin pointer (auto_mode=1). Each channel
// holds its word until the downstream consumer takes it via z_ready, and an
// 8-bit delivered-word counter per channel tracks how many words were taken.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   d          in   WIDTH  input data word
//   sel        in   2      destination channel when auto_mode=0
//   auto_mode  in   1      1 = round-robin destination, sel ignored
//   in_valid   in   1      d/sel valid this cycle
//   in_ready   out  1      block accepts d this cycle
//   z0..z3     out  WIDTH  channel data registers
//   z_valid    out  4      bit k = channel k holds undelivered data
//   z_ready    in   4      bit k = channel k consumer takes data
//   rr_ptr     out  2      next round-robin destination
//   cnt        out  32     delivered-word counters, cnt[8k+7:8k] = channel k
// -----------------------------------------------------------------------------
module demux4_buf #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    input  logic             auto_mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] z0,
    output logic [WIDTH-1:0] z1,
    output logic [WIDTH-1:0] z2,
    output logic [WIDTH-1:0] z3,
    output logic [3:0]       z_valid,
    input  logic [3:0]       z_ready,
    output logic [1:0]       rr_ptr,
    output logic [31:0]      cnt
);

    // Round-robin advance; natural 2-bit wrap gives 3 -> 0.
    function automatic logic [1:0] rr_next(input logic [1:0] cur);
        return cur + 2'd1;
    endfunction

    // Delivered-word counter advance; wraps 255 -> 0, never saturates.
    function automatic logic [7:0] cnt_next(input logic [7:0] cur);
        return cur + 8'd1;
    endfunction

    logic [WIDTH-1:0] data_p1 [4];
    logic [3:0]       vld_p1;
    logic [7:0]       cnt_p1  [4];
    logic [1:0]       rr_p1;

    logic [1:0]       target;
    logic             accept;
    logic [3:0]       load;
    logic [3:0]       drain;

    // Input steering and handshake (combinational)
    assign target   = auto_mode ? rr_p1 : sel;
    // A full target channel can still take a word if it is being drained in
    // the same cycle, so there is no bubble under continuous flow.
    assign in_ready = !vld_p1[target] | z_ready[target];
    assign accept   = in_valid & in_ready;

    always_comb begin
        load  = '0;
        drain = '0;
        for (int k = 0; k < 4; k++) begin
            load[k]  = accept && (target == 2'(k));
            drain[k] = vld_p1[k] & z_ready[k];
        end
    end

    // Channel data registers: only overwritten by a load, so the last word
    // stays visible after it has been delivered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                data_p1[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    data_p1[k] <= d;
                end
            end
        end
    end

    // Channel valid flags: a load wins over a drain in the same cycle, which
    // keeps the flag set for the freshly loaded word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    vld_p1[k] <= 1'b1;
                end else if (drain[k]) begin
                    vld_p1[k] <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointer: only moves on an accepted word in auto mode, so
    // switching back into auto mode resumes from where it left off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_p1 <= '0;
        end else if (accept && auto_mode) begin
            rr_p1 <= rr_next(rr_p1);
        end
    end

    // Delivered-word counters, one per channel, independent of each other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                cnt_p1[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (drain[k]) begin
                    cnt_p1[k] <= cnt_next(cnt_p1[k]);
                end
            end
        end
    end

    // Output mapping
    assign z0      = data_p1[0];
    assign z1      = data_p1[1];
    assign z2      = data_p1[2];
    assign z3      = data_p1[3];
    assign z_valid = vld_p1;
    assign rr_ptr  = rr_p1;
    assign cnt     = {cnt_p1[3], cnt_p1[2], cnt_p1[1], cnt_p1[0]};

endmodule

// File: tb/tb_demux4_buf.sv
module tb_demux4_buf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [0:0]  d;
    logic [1:0]  sel;
    logic        auto_mode;
    logic        in_valid;
    logic        in_ready;
    logic [0:0]  z0, z1, z2, z3;
    logic [3:0]  z_valid;
    logic [3:0]  z_ready;
    logic [1:0]  rr_ptr;
    logic [31:0] cnt;
    logic [3:0]  zb;

    int vec_cnt = 0;
    int err_cnt = 0;

    demux4_buf #(.WIDTH(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d         (d),
        .sel       (sel),
        .auto_mode (auto_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z0        (z0),
        .z1        (z1),
        .z2        (z2),
        .z3        (z3),
        .z_valid   (z_valid),
        .z_ready   (z_ready),
        .rr_ptr    (rr_ptr),
        .cnt       (cnt)
    );

    assign zb = {z3, z2, z1, z0};

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; in_valid = 1'b0; sel = 2'd0; auto_mode = 1'b0;
        d = 1'b0; z_ready = 4'b0000;
        step;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        in_valid = 1'b1; sel = 2'd2; auto_mode = 1'b0; d = 1'b1; z_ready = 4'b0000;
        #1 rst_n = 1'b0;
        #1;
        vec_cnt++; if (z_valid !== 4'b0000) begin err_cnt++; $display("FAIL rst_zvalid: got %b expected %b", z_valid, 4'b0000); end
        vec_cnt++; if (cnt !== 32'h0) begin err_cnt++; $display("FAIL rst_cnt: got %h expected %h", cnt, 32'h0); end
        vec_cnt++; if (rr_ptr !== 2'd0) begin err_cnt++; $display("FAIL rst_rr: got %0d expected 0", rr_ptr); end
        vec_cnt++; if (zb !== 4'b0000) begin err_cnt++; $display("FAIL rst_z: got %b expected %b", zb, 4'b0000); end
        vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        step;
        vec_cnt++; if (z_valid !== 4'b0000) begin err_cnt++; $display("FAIL rst_ignore_accept: got %b expected %b", z_valid, 4'b0000); end
        rst_n = 1'b1;
    endtask

    task automatic test_manual;
        logic [3:0] exp;
        do_reset;
        auto_mode = 1'b0; z_ready = 4'b1111; d = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sel = 2'(k);
            step;
            exp = 4'b0001 << k;
            vec_cnt++; if (z_valid !== exp) begin err_cnt++; $display("FAIL man_zvalid_%0d: got %b expected %b", k, z_valid, exp); end
            vec_cnt++; if (zb[k] !== 1'b1) begin err_cnt++; $display("FAIL man_z_%0d: got %b expected 1", k, zb[k]); end
        end
        in_valid = 1'b0;
        step;
        vec_cnt++; if (z_valid !== 4'b0000) begin err_cnt++; $display("FAIL man_cleared: got %b expected %b", z_valid, 4'b0000); end
        vec_cnt++; if (cnt !== 32'h01010101) begin err_cnt++; $display("FAIL man_cnt: got %h expected %h", cnt, 32'h01010101); end
        vec_cnt++; if (zb !== 4'b1111) begin err_cnt++; $display("FAIL man_hold: got %b expected %b", zb, 4'b1111); end
    endtask

    task automatic test_backpressure;
        do_reset;
        auto_mode = 1'b0; z_ready = 4'b0000; sel = 2'd2; d = 1'b1; in_valid = 1'b1;
        vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_ready_first: got %b expected 1", in_ready); end
        step;
        vec_cnt++; if (z_valid !== 4'b0100) begin err_cnt++; $display("FAIL bp_valid_first: got %b expected %b", z_valid, 4'b0100); end
        vec_cnt++; if (z2 !== 1'b1) begin err_cnt++; $display("FAIL bp_z2_first: got %b expected 1", z2); end
        d = 1'b0;
        #1;
        vec_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL bp_ready_blocked: got %b expected 0", in_ready); end
        step;
        vec_cnt++; if (z2 !== 1'b1) begin err_cnt++; $display("FAIL bp_z2_held: got %b expected 1", z2); end
        vec_cnt++; if (z_valid !== 4'b0100) begin err_cnt++; $display("FAIL bp_valid_held: got %b expected %b", z_valid, 4'b0100); end
        vec_cnt++; if (cnt !== 32'h0) begin err_cnt++; $display("FAIL bp_cnt_held: got %h expected %h", cnt, 32'h0); end
        z_ready = 4'b0100;
        #1;
        vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_ready_release: got %b expected 1", in_ready); end
        step;
        vec_cnt++; if (z2 !== 1'b0) begin err_cnt++; $display("FAIL bp_z2_second: got %b expected 0", z2); end
        vec_cnt++; if (z_valid !== 4'b0100) begin err_cnt++; $display("FAIL bp_valid_second: got %b expected %b", z_valid, 4'b0100); end
        vec_cnt++; if (cnt[23:16] !== 8'd1) begin err_cnt++; $display("FAIL bp_cnt2: got %0d expected 1", cnt[23:16]); end
        in_valid = 1'b0;
        step;
        vec_cnt++; if (z_valid !== 4'b0000) begin err_cnt++; $display("FAIL bp_drained: got %b expected %b", z_valid, 4'b0000); end
        vec_cnt++; if (cnt !== 32'h00020000) begin err_cnt++; $display("FAIL bp_cnt_final: got %h expected %h", cnt, 32'h00020000); end
    endtask

    task automatic test_auto;
        logic [3:0] exp;
        logic [0:0] dv;
        do_reset;
        auto_mode = 1'b1; z_ready = 4'b1111; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sel = 2'(3 - (i % 4));
            dv  = (i % 2 == 0) ? 1'b1 : 1'b0;
            d   = dv;
            #1;
            vec_cnt++; if (rr_ptr !== 2'(i % 4)) begin err_cnt++; $display("FAIL auto_rr_%0d: got %0d expected %0d", i, rr_ptr, i % 4); end
            step;
            exp = 4'b0001 << (i % 4);
            vec_cnt++; if (z_valid !== exp) begin err_cnt++; $display("FAIL auto_dest_%0d: got %b expected %b", i, z_valid, exp); end
            vec_cnt++; if (zb[i % 4] !== dv) begin err_cnt++; $display("FAIL auto_data_%0d: got %b expected %b", i, zb[i % 4], dv); end
        end
        vec_cnt++; if (rr_ptr !== 2'd1) begin err_cnt++; $display("FAIL auto_rr_end: got %0d expected 1", rr_ptr); end
        // Manual word in between must not move the pointer.
        auto_mode = 1'b0; sel = 2'd3; d = 1'b1;
        step;
        vec_cnt++; if (z_valid !== 4'b1000) begin err_cnt++; $display("FAIL auto_manual_dest: got %b expected %b", z_valid, 4'b1000); end
        vec_cnt++; if (rr_ptr !== 2'd1) begin err_cnt++; $display("FAIL auto_manual_rr: got %0d expected 1", rr_ptr); end
        auto_mode = 1'b1; sel = 2'd3;
        step;
        vec_cnt++; if (z_valid !== 4'b0010) begin err_cnt++; $display("FAIL auto_resume_dest: got %b expected %b", z_valid, 4'b0010); end
        vec_cnt++; if (rr_ptr !== 2'd2) begin err_cnt++; $display("FAIL auto_resume_rr: got %0d expected 2", rr_ptr); end
        in_valid = 1'b0;
        step;
        vec_cnt++; if (cnt !== 32'h02010202) begin err_cnt++; $display("FAIL auto_cnt: got %h expected %h", cnt, 32'h02010202); end
        vec_cnt++; if (z_valid !== 4'b0000) begin err_cnt++; $display("FAIL auto_drained: got %b expected %b", z_valid, 4'b0000); end
    endtask

    task automatic test_wrap;
        do_reset;
        auto_mode = 1'b0; z_ready = 4'b1111; in_valid = 1'b1; sel = 2'd1; d = 1'b1;
        step;
        sel = 2'd3;
        for (int i = 0; i < 256; i++) begin
            d = 1'(i);
            step;
        end
        vec_cnt++; if (z_valid !== 4'b1000) begin err_cnt++; $display("FAIL wrap_valid: got %b expected %b", z_valid, 4'b1000); end
        vec_cnt++; if (cnt !== 32'hFF000100) begin err_cnt++; $display("FAIL wrap_cnt_255: got %h expected %h", cnt, 32'hFF000100); end
        in_valid = 1'b0;
        step;
        vec_cnt++; if (cnt !== 32'h00000100) begin err_cnt++; $display("FAIL wrap_cnt_0: got %h expected %h", cnt, 32'h00000100); end
        vec_cnt++; if (z_valid !== 4'b0000) begin err_cnt++; $display("FAIL wrap_drained: got %b expected %b", z_valid, 4'b0000); end
    endtask

    task automatic test_async_reset;
        do_reset;
        auto_mode = 1'b0; z_ready = 4'b1111; sel = 2'd0; d = 1'b1; in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        step;
        z_ready = 4'b0000; auto_mode = 1'b1; in_valid = 1'b1;
        repeat (3) step;
        auto_mode = 1'b0; sel = 2'd3;
        step;
        in_valid = 1'b0;
        vec_cnt++; if (z_valid !== 4'b1111) begin err_cnt++; $display("FAIL ar_loaded: got %b expected %b", z_valid, 4'b1111); end
        vec_cnt++; if (rr_ptr !== 2'd3) begin err_cnt++; $display("FAIL ar_rr_before: got %0d expected 3", rr_ptr); end
        vec_cnt++; if (cnt !== 32'h00000001) begin err_cnt++; $display("FAIL ar_cnt_before: got %h expected %h", cnt, 32'h1); end
        #2 rst_n = 1'b0;
        #1;
        vec_cnt++; if (z_valid !== 4'b0000) begin err_cnt++; $display("FAIL ar_zvalid: got %b expected %b", z_valid, 4'b0000); end
        vec_cnt++; if (cnt !== 32'h0) begin err_cnt++; $display("FAIL ar_cnt: got %h expected %h", cnt, 32'h0); end
        vec_cnt++; if (rr_ptr !== 2'd0) begin err_cnt++; $display("FAIL ar_rr: got %0d expected 0", rr_ptr); end
        vec_cnt++; if (zb !== 4'b0000) begin err_cnt++; $display("FAIL ar_z: got %b expected %b", zb, 4'b0000); end
        vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL ar_in_ready: got %b expected 1", in_ready); end
        in_valid = 1'b1; sel = 2'd2;
        step;
        vec_cnt++; if (z_valid !== 4'b0000) begin err_cnt++; $display("FAIL ar_ignored: got %b expected %b", z_valid, 4'b0000); end
        rst_n = 1'b1; sel = 2'd1; auto_mode = 1'b0; d = 1'b1;
        step;
        vec_cnt++; if (z_valid !== 4'b0010) begin err_cnt++; $display("FAIL ar_first_valid: got %b expected %b", z_valid, 4'b0010); end
        vec_cnt++; if (zb !== 4'b0010) begin err_cnt++; $display("FAIL ar_first_z: got %b expected %b", zb, 4'b0010); end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset;
        test_manual;
        test_backpressure;
        test_auto;
        test_wrap;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
